// File: rtl/bit_serial_addsub_pkg.sv
// Shared definitions for the bit-serial adder/subtractor.
// FSM state encodings used by the top-level controller.
package bit_serial_addsub_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/bit_serial_addsub_full_adder.sv
// Single-bit full adder slice.
// Combinational sum and carry for one operand bit pair.
module bit_serial_addsub_full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/bit_serial_addsub.sv
// Bit-serial adder/subtractor: one bit pair per cycle, LSB first.
// Valid/ready handshakes on the operand and result sides.
import bit_serial_addsub_pkg::*;

module bit_serial_addsub #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             result_valid,
    input  logic             result_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             overflow,
    output logic             zero,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t state;
    state_t state_next;

    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             carry;
    logic [CW-1:0]    bit_cnt;
    logic             fa_sum;
    logic             fa_cout;
    logic             last_bit;
    logic [WIDTH-1:0] result_next;

    assign last_bit    = (bit_cnt == LAST);
    assign result_next = {fa_sum, result[WIDTH-1:1]};

    bit_serial_addsub_full_adder u_fa (
        .a    (op_a[0]),
        .b    (op_b[0]),
        .cin  (carry),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    // Next-state and handshake outputs
    always_comb begin
        state_next   = state;
        start_ready  = 1'b0;
        result_valid = 1'b0;
        busy         = 1'b0;
        unique case (state)
            S_IDLE: begin
                start_ready = 1'b1;
                if (start_valid) state_next = S_RUN;
            end
            S_RUN: begin
                busy = 1'b1;
                if (last_bit) state_next = S_DONE;
            end
            S_DONE: begin
                busy         = 1'b1;
                result_valid = 1'b1;
                if (result_ready) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Operand load, serial shift and flag capture
    always_ff @(posedge clk) begin
        if (reset) begin
            op_a     <= '0;
            op_b     <= '0;
            carry    <= 1'b0;
            bit_cnt  <= '0;
            result   <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
            zero     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_valid) begin
                        op_a    <= a;
                        op_b    <= sub ? ~b : b;
                        carry   <= sub;
                        bit_cnt <= '0;
                    end
                end
                S_RUN: begin
                    result <= result_next;
                    op_a   <= op_a >> 1;
                    op_b   <= op_b >> 1;
                    carry  <= fa_cout;
                    if (last_bit) begin
                        cout     <= fa_cout;
                        overflow <= carry ^ fa_cout;
                        zero     <= (result_next == '0);
                    end else begin
                        bit_cnt <= bit_cnt + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
